// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_e;

    function automatic logic op_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side request/result bundle of the multiply/divide unit.
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
        shl     = {acc, q[WIDTH-1]};
        acc_nxt = sum[WIDTH:1];
        q_nxt   = {sum[0], q[WIDTH-1:1]};
        if (is_div) begin
            // remainder stays below d, so the trial difference always fits WIDTH bits
            if (shl >= {1'b0, d}) begin
                acc_nxt = shl[WIDTH-1:0] - d;
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shl[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: magnitude iteration over WIDTH cycles, then sign fix-up.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    muldiv_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             b_zero;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] a_raw;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    assign a_neg = op_signed(bus.op) & bus.src_a[WIDTH-1];
    assign b_neg = op_signed(bus.op) & bus.src_b[WIDTH-1];
    assign a_mag = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag = b_neg ? -bus.src_b : bus.src_b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc     (acc),
        .q       (q),
        .d       (d),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    // Quotient and product take sign a^b; remainder takes the dividend's sign.
    always_comb begin
        prod_fix = neg_lo ? -{acc, q} : {acc, q};
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                hi_fix = a_raw;
                lo_fix = '1;
            end else begin
                hi_fix = neg_hi ? -acc : acc;
                lo_fix = neg_lo ? -q : q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            count           <= '0;
            is_div          <= 1'b0;
            neg_lo          <= 1'b0;
            neg_hi          <= 1'b0;
            b_zero          <= 1'b0;
            acc             <= '0;
            q               <= '0;
            d               <= '0;
            a_raw           <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        is_div          <= op_is_div(bus.op);
                        neg_lo          <= a_neg ^ b_neg;
                        neg_hi          <= a_neg;
                        b_zero          <= (bus.src_b == '0);
                        a_raw           <= bus.src_a;
                        acc             <= '0;
                        q               <= a_mag;
                        d               <= b_mag;
                        count           <= '0;
                        bus.div_by_zero <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= ST_RUN;
                    end else begin
                        if (bus.wr_hi) bus.hi <= bus.wr_data;
                        if (bus.wr_lo) bus.lo <= bus.wr_data;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_nxt;
                    q     <= q_nxt;
                    count <= count + 1'b1;
                    if (count == LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    bus.hi          <= hi_fix;
                    bus.lo          <= lo_fix;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    bus.div_by_zero <= is_div & b_zero;
                    state           <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, holding the architectural HI/LO registers. It consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU. It produces HI/LO, which MFHI/MFLO later return to the register-file write port. Operations are multi-cycle (WIDTH+2 cycles from start to done), with a busy/done handshake toward the pipeline control.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; RUN phase lasts WIDTH cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- src_a  in  WIDTH  rs operand (multiplicand / dividend).
- src_b  in  WIDTH  rt operand (multiplier / divisor).
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wr_data  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high while an operation is in flight (RUN or FIX).
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- div_by_zero  out  1  set when a DIV/DIVU with src_b==0 completes; cleared on the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1: latch op, |src_a|, |src_b| (magnitudes only for signed ops), and the result signs. Clear count and div_by_zero. Go to RUN.
- RUN: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle. count runs 0..WIDTH-1. At count==WIDTH-1, go to FIX.
- FIX: apply sign correction and write hi/lo. Set done=1 for the next cycle. Go to IDLE.
- Multiply result: {hi,lo} = full 2·WIDTH product (signed for MULT, unsigned for MULTU).
- Divide result: lo = quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
- Divide by zero (either DIV or DIVU): hi=src_a as latched, lo=all-ones, div_by_zero=1. Same latency as a normal divide.
- DIV overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- start while busy: ignored. No queueing, no effect on the op in flight.
- wr_hi/wr_lo: take effect only in IDLE when start=0. They are ignored while busy, and ignored when start=1 in the same cycle (start wins). If both strobes are high, both registers are written.
- Reset (any state, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, count=0. An aborted op never asserts done.

## Timing
- start high in cycle 0, accepted at the end of cycle 0.
- busy=1 in cycles 1..WIDTH+1: RUN occupies cycles 1..WIDTH, FIX is cycle WIDTH+1.
- In cycle WIDTH+2 (34 for WIDTH=32): done=1, busy=0, hi/lo show the result.
- A new start is accepted in that same done cycle (back-to-back issue every WIDTH+2 cycles).
- hi/lo are unchanged during RUN/FIX, so MFHI/MFLO during busy read the previous values. Stalling MFHI/MFLO is the pipeline control's job, using busy.
- MTHI/MTLO write is visible on hi/lo the cycle after the strobe.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package muldiv_pkg holds: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum (ST_IDLE, ST_RUN, ST_FIX), and the default WIDTH constant.
- One sub-module, muldiv_step: the combinational single-iteration datapath. It takes the mode and the current partial accumulator/remainder plus shift register, and returns the next values.
- The top level holds the FSM, counter, operand/sign latches, sign fix-up, and the HI/LO registers.

## Test plan
- MULT src_a=0xFFFFFFFD (-3), src_b=7 -> done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/0 -> hi=100, lo=0xFFFFFFFF, div_by_zero=1. A following MULTU start clears div_by_zero in the next cycle.
- Start MULTU 5×6, then pulse start with op=DIV and wr_lo=1 (wr_data=0x1234) at cycle 10 -> both are ignored; done at 34 with hi=0, lo=30. Then wr_lo in IDLE -> lo=0x1234 the next cycle.
- Start DIVU, assert rst at cycle 10 -> busy=0 and hi=lo=0 from cycle 11; done never pulses. A new start after reset completes normally.
